// File: rtl/alu_if.sv
// Operand/result bundle for the single-cycle ALU.
// The master drives the operands and the operation select. The slave (the ALU) returns
// the registered result and its flags.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       aluop;
    logic             in_valid;
    logic [WIDTH-1:0] res;
    logic             out_valid;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output a, b, aluop, in_valid,
        input  res, out_valid, carry, zero, neg, ovf
    );

    modport slave (
        input  a, b, aluop, in_valid,
        output res, out_valid, carry, zero, neg, ovf
    );
endinterface

// File: rtl/alu.sv
// Registered ALU with one cycle of latency: add, sub, logical left shift and bitwise and.
// It produces carry, zero, neg and ovf flags, and accepts one operation on every cycle.
// When no operation is presented, the result and flags hold their previous values.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

    // Returns {ovf, carry, res}. Each operation runs on a WIDTH+1 bit datapath,
    // so bit WIDTH is the carry:
    // - add: it is the sum carry-out.
    // - sub: a + ~b + 1 leaves the no-borrow bit there.
    // - shift: it is the last bit shifted out, which is a[WIDTH-sh]. It is 0 when sh == 0.
    function automatic logic [WIDTH+1:0] compute(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [1:0]       op
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH:0]   wide;
        logic                    v;
        logic        [SH_W-1:0]  sh;
        sa   = op_a;
        sb   = op_b;
        sh   = op_b[SH_W-1:0];
        wide = '0;
        v    = 1'b0;
        case (op)
            2'b00: begin
                wide = {1'b0, op_a} + {1'b0, op_b};
                v    = ((sa < 0) == (sb < 0)) && (wide[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b01: begin
                wide = {1'b0, op_a} + {1'b0, ~op_b} + ONE_W;
                v    = ((sa < 0) != (sb < 0)) && (wide[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b10: begin
                wide = {1'b0, op_a} << sh;
            end
            default: begin
                wide = {1'b0, op_a & op_b};
            end
        endcase
        return {v, wide};
    endfunction

    logic [WIDTH+1:0] calc_p0;
    logic [WIDTH-1:0] res_p1;
    logic             carry_p1;
    logic             zero_p1;
    logic             neg_p1;
    logic             ovf_p1;
    logic             vld_p1;

    // Combinational evaluation of the presented operation (stage p0)
    always_comb begin
        calc_p0 = compute(bus.a, bus.b, bus.aluop);
    end

    // Output register (stage p1): reset has priority; data updates only on a valid operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            res_p1   <= '0;
            carry_p1 <= 1'b0;
            zero_p1  <= 1'b1;
            neg_p1   <= 1'b0;
            ovf_p1   <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                res_p1   <= calc_p0[WIDTH-1:0];
                carry_p1 <= calc_p0[WIDTH];
                ovf_p1   <= calc_p0[WIDTH+1];
                zero_p1  <= (calc_p0[WIDTH-1:0] == '0);
                neg_p1   <= calc_p0[WIDTH-1];
            end
        end
    end

    assign bus.res       = res_p1;
    assign bus.carry     = carry_p1;
    assign bus.zero      = zero_p1;
    assign bus.neg       = neg_p1;
    assign bus.ovf       = ovf_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU.
// The vector table is applied back to back, so a new operation is presented every cycle.
// Hand-written sequences then cover hold, reset, and operand changes between edges.
module tb_alu;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       neg;
        logic       ovf;
    } vec_t;

    vec_t vecs[15];
    int   applied;
    int   errors;

    // Observed outputs packed as {out_valid, res, carry, zero, neg, ovf}
    function automatic logic [12:0] observed();
        return {bus.out_valid, bus.res, bus.carry, bus.zero, bus.neg, bus.ovf};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        applied++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got vld=%0b res=%h c=%0b z=%0b n=%0b v=%0b, want vld=%0b res=%h c=%0b z=%0b n=%0b v=%0b",
                     name, got[12], got[11:4], got[3], got[2], got[1], got[0],
                     exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.aluop    = op;
        bus.in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applied = 0;
        errors  = 0;

        //            a      b      op     res    c     z     n     v
        vecs[0]  = '{8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h81, 8'h01, 2'b10, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h0F, 8'hFC, 2'b10, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h3C, 8'h44, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{8'h07, 8'h07, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h00, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{8'h01, 8'h07, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h03, 8'h07, 2'b10, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'hFF, 8'hA5, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'h7F, 8'hFF, 2'b01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{8'hF0, 8'h0F, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with a valid operation presented: the operation must be discarded
        rst_n = 1'b0;
        drive(8'hFF, 8'h01, 2'b00, 1'b1);
        step();
        step();
        check("reset_state", observed(), {1'b1 ^ 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

        // Back-to-back table, one new operation per cycle
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            step();
            check($sformatf("vec%0d", i), observed(),
                  {1'b1, vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].neg, vecs[i].ovf});
        end

        // The last vector was the and giving 00. An idle cycle must drop out_valid and hold
        // everything else.
        drive(8'h7F, 8'h01, 2'b00, 1'b0);
        step();
        check("idle_hold", observed(), {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

        // Valid again after the idle cycle
        drive(8'h7F, 8'h01, 2'b00, 1'b1);
        step();
        check("after_idle", observed(), {1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1});

        // Operand changes between edges must not reach the outputs
        drive(8'hFF, 8'h01, 2'b00, 1'b1);
        #2;
        check("no_comb_path", observed(), {1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
        step();
        check("comb_then_edge", observed(), {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

        // Mid-stream reset. Lowering rst_n between edges must change nothing;
        // the next edge resets everything.
        drive(8'h05, 8'h07, 2'b01, 1'b1);
        step();
        check("pre_reset", observed(), {1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0});
        drive(8'h80, 8'h01, 2'b01, 1'b1);
        rst_n = 1'b0;
        #2;
        check("rst_no_edge", observed(), {1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0});
        step();
        check("mid_reset", observed(), {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

        // Release reset. The first operation after release appears one cycle later.
        rst_n = 1'b1;
        drive(8'h81, 8'h01, 2'b10, 1'b1);
        step();
        check("post_reset", observed(), {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});

        drive(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        check("final_idle", observed(), {1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; all values below assume WIDTH=8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  WIDTH  operand A, unsigned / two's complement.
REQ-005 b  input  WIDTH  operand B.
REQ-006 aluop  input  2  operation select: 00 add, 01 sub, 10 shift, 11 and.
REQ-007 in_valid  input  1  operands and aluop valid this cycle.
REQ-008 res  output  WIDTH  registered result.
REQ-009 out_valid  output  1  res and flags valid, registered.
REQ-010 carry  output  1  add carry-out, sub no-borrow, or shift last bit out.
REQ-011 zero  output  1  res == 0.
REQ-012 neg  output  1  res[WIDTH-1].
REQ-013 ovf  output  1  signed overflow for add/sub; 0 otherwise.

Function
REQ-014 add: res = (a + b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum; ovf = a, b same sign and res sign differs.
REQ-015 sub: res = (a - b) mod 2^WIDTH, computed as a + ~b + 1; carry = 1 when a >= b unsigned (no borrow); ovf = a, b signs differ and res sign differs from a.
REQ-016 shift: logical left shift, res = a << b[2:0] with zero fill; b[7:3] ignored; carry = a[WIDTH - b[2:0]] when b[2:0] != 0, else 0; ovf = 0.
REQ-017 and: res = a & b bitwise; carry = 0; ovf = 0.
REQ-018 zero and neg derived from the new res value in every op.
REQ-019 Latency exactly 1 cycle: inputs sampled at rising edge with in_valid=1 appear on res/flags after that edge, with out_valid=1.
REQ-020 in_valid=0 at an edge: out_valid goes 0 at that edge; res and flags hold their previous values.
REQ-021 Back-to-back in_valid=1 accepted every cycle; no stall, no backpressure; throughput 1 op/cycle.
REQ-022 Operand changes between edges have no effect on outputs; no combinational path from inputs to outputs.
REQ-023 Wrap-around: results never exceed WIDTH bits; overflow bits visible only via carry/ovf.

Reset
REQ-024 rst_n=0 at a rising edge: res=0, out_valid=0, carry=0, zero=1, neg=0, ovf=0 after that edge.
REQ-025 Reset has priority over in_valid; an operation presented in the reset cycle is discarded.
REQ-026 Reset asserted mid-stream aborts the pending result; first valid result after release follows REQ-019.
REQ-027 No output changes on rst_n edges alone; reset acts only at clk rising edges.

Verification
REQ-028 add: a=8'h7F, b=8'h01, aluop=00, in_valid=1 -> next cycle res=8'h80, carry=0, ovf=1, neg=1, zero=0, out_valid=1.
REQ-029 add wrap: a=8'hFF, b=8'h01, aluop=00 -> res=8'h00, carry=1, zero=1, ovf=0.
REQ-030 sub: a=8'h05, b=8'h07, aluop=01 -> res=8'hFE, carry=0, neg=1, ovf=0; then a=8'h80, b=8'h01 -> res=8'h7F, carry=1, ovf=1.
REQ-031 shift: a=8'h81, b=8'h01, aluop=10 -> res=8'h02, carry=1; a=8'h0F, b=8'hFC (shift 4) -> res=8'hF0, carry=0.
REQ-032 and: a=8'hF0, b=8'h0F, aluop=11 -> res=8'h00, zero=1, carry=0; then in_valid=0 one cycle -> out_valid=0, res holds 8'h00.
REQ-033 reset: stream valid ops each cycle, drive rst_n=0 one cycle -> all outputs per REQ-024 on that edge; next valid op after release appears 1 cycle later.
